// File: rtl/byte_pkt_pkg.sv
// Shared constants and state encoding for the byte-stream packet arbiter and
// any later multi-packetizer scheduler built around rr_pick.
package byte_pkt_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   function automatic int f_pkt_bytes(input int symbols, input int bytes_per_symbol);
      return symbols * bytes_per_symbol;
   endfunction

   function automatic int f_cnt_w(input int pkt_bytes);
      return $clog2(pkt_bytes);
   endfunction

   function automatic int f_idx_w(input int num_req);
      return $clog2(num_req);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set bit of i_req searching upward
// from i_last+1 with wrap-around.
module rr_pick
   import byte_pkt_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = f_idx_w(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   int w_pos;

   // Walk the candidates farthest-first so the nearest one after i_last wins.
   always_comb begin
      o_found = |i_req;
      o_idx   = '0;
      w_pos   = 0;
      for (int k = N; k >= 1; k--) begin
         w_pos = (int'(i_last) + k) % N;
         if (i_req[w_pos[IW-1:0]]) o_idx = w_pos[IW-1:0];
      end
   end

endmodule

// File: rtl/byte_stream_packet_arbiter.sv
// Grants one byte-stream requester the packetizer sink for one whole packet,
// then re-arbitrates round-robin. Option: BYTE_STREAM_ARB_CHANNEL_EN adds chan_mask/aso_out0_channel.
module byte_stream_packet_arbiter
   import byte_pkt_pkg::*;
#(
   parameter  int NUM_REQ           = 4,
   parameter  int SYMBOL_PER_PACKET = 256,
   parameter  int BYTES_PER_SYMBOL  = 8,
   parameter  int BITS_PER_BYTES    = 8,
   localparam int PKT_BYTES         = f_pkt_bytes(SYMBOL_PER_PACKET, BYTES_PER_SYMBOL),
   localparam int CNT_W             = f_cnt_w(PKT_BYTES),
   localparam int IDX_W             = f_idx_w(NUM_REQ)
)(
   input  logic                              clock_clk,
   input  logic                              reset_reset,
   input  logic [NUM_REQ*BITS_PER_BYTES-1:0] asi_in_data,
   input  logic [NUM_REQ-1:0]                asi_in_valid,
   output logic [NUM_REQ-1:0]                asi_in_ready,
   output logic [BITS_PER_BYTES-1:0]         aso_out0_data,
   output logic                              aso_out0_valid,
   input  logic                              aso_out0_ready,
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
   input  logic [NUM_REQ-1:0]                chan_mask,
   output logic [IDX_W-1:0]                  aso_out0_channel,
`endif
   output logic                              grant_active,
   output logic [IDX_W-1:0]                  grant_index
);

   state_t                                   r_state, w_next;
   logic [CNT_W-1:0]                         r_cnt;
   logic [IDX_W-1:0]                         r_last, r_gidx, w_pick_idx;
   logic                                     w_found, w_hs, w_last_byte;
   logic [NUM_REQ-1:0]                       w_elig;
   logic [NUM_REQ-1:0][BITS_PER_BYTES-1:0]   w_bytes;

   assign w_bytes = asi_in_data;

`ifdef BYTE_STREAM_ARB_CHANNEL_EN
   // Mask is only consulted by the IDLE pick, so changes land at the next IDLE.
   assign w_elig           = asi_in_valid & chan_mask;
   assign aso_out0_channel = r_gidx;
`else
   assign w_elig           = asi_in_valid;
`endif

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req   (w_elig),
      .i_last  (r_last),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   assign w_hs         = (r_state == XFER) && asi_in_valid[r_gidx] && aso_out0_ready;
   assign w_last_byte  = (r_cnt == CNT_W'(PKT_BYTES - 1));
   assign grant_active = (r_state == XFER);
   assign grant_index  = r_gidx;

   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_gidx  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_found) r_gidx <= w_pick_idx;
         if (w_hs) begin
            if (w_last_byte) begin
               r_cnt  <= '0;
               r_last <= r_gidx;
            end else begin
               r_cnt  <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Ready/valid/data are combinational from state so a reset drops them at once.
   always_comb begin
      w_next         = r_state;
      asi_in_ready   = '0;
      aso_out0_valid = 1'b0;
      aso_out0_data  = '0;
      unique case (r_state)
         IDLE: begin
            if (w_found) w_next = XFER;
         end
         XFER: begin
            aso_out0_data        = w_bytes[r_gidx];
            aso_out0_valid       = asi_in_valid[r_gidx];
            asi_in_ready[r_gidx] = aso_out0_ready;
            if (w_hs && w_last_byte) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_byte_stream_packet_arbiter.sv
// Self-checking bench: directed scenarios plus a random phase, compared each
// cycle against a packet-level round-robin reference model.
module tb_byte_stream_packet_arbiter;

   localparam int NR  = 4;
   localparam int PKT = 4;

   logic           clock_clk = 1'b0;
   logic           reset_reset;
   logic [NR*8-1:0] asi_in_data;
   logic [NR-1:0]  asi_in_valid;
   logic [NR-1:0]  asi_in_ready;
   logic [7:0]     aso_out0_data;
   logic           aso_out0_valid;
   logic           aso_out0_ready;
   logic           grant_active;
   logic [1:0]     grant_index;
   logic [NR-1:0]  chan_mask = 4'b1111;
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
   logic [1:0]     aso_out0_channel;
`endif

   byte_stream_packet_arbiter #(
      .NUM_REQ(NR), .SYMBOL_PER_PACKET(2), .BYTES_PER_SYMBOL(2), .BITS_PER_BYTES(8)
   ) dut (
      .clock_clk        (clock_clk),
      .reset_reset      (reset_reset),
      .asi_in_data      (asi_in_data),
      .asi_in_valid     (asi_in_valid),
      .asi_in_ready     (asi_in_ready),
      .aso_out0_data    (aso_out0_data),
      .aso_out0_valid   (aso_out0_valid),
      .aso_out0_ready   (aso_out0_ready),
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
      .chan_mask        (chan_mask),
      .aso_out0_channel (aso_out0_channel),
`endif
      .grant_active     (grant_active),
      .grant_index      (grant_index)
   );

   always #5 clock_clk = ~clock_clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: who owns the sink, bytes moved in this packet, last owner,
   // and per-requester stream position (each requester emits {id, seq}).
   bit m_busy;
   int m_owner, m_cnt, m_last;
   int m_seq[NR];
   int drv_seq[NR];
   bit prev_ga;
   int grants[$];

   function automatic logic [7:0] mk(input int id, input int seq);
      logic [3:0] a, b;
      a = id[3:0];
      b = seq[3:0];
      return {a, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_cnt   = 0;
      m_last  = NR - 1;
      prev_ga = 0;
   endtask

   task automatic model_step(input logic [NR-1:0] v, input logic r);
      logic [NR-1:0] elig;
      bit found;
      int j;
      elig = v;
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
      elig = v & chan_mask;
`endif
      if (!m_busy) begin
         found = 0;
         for (int k = 1; k <= NR; k++) begin
            j = (m_last + k) % NR;
            if (!found && elig[j]) begin
               found = 1;
               m_owner = j;
            end
         end
         m_busy = found;
      end else if (v[m_owner] && r) begin
         m_seq[m_owner]++;
         m_cnt++;
         if (m_cnt == PKT) begin
            m_busy = 0;
            m_cnt  = 0;
            m_last = m_owner;
         end
      end
   endtask

   task automatic check_outputs(input logic [NR-1:0] v, input logic r);
      logic [NR-1:0] er;
      er = (m_busy && r) ? (4'b0001 << m_owner) : 4'b0000;
      chk("grant_active", 32'(grant_active), 32'(m_busy));
      chk("grant_index", 32'(grant_index), 32'(m_owner));
      chk("in_ready", 32'(asi_in_ready), 32'(er));
      chk("out_valid", 32'(aso_out0_valid), 32'(m_busy && v[m_owner]));
      if (!m_busy) chk("idle_data", 32'(aso_out0_data), 32'h0);
      else if (v[m_owner]) chk("out_data", 32'(aso_out0_data), 32'(mk(m_owner, m_seq[m_owner])));
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
      if (m_busy && v[m_owner]) chk("channel", 32'(aso_out0_channel), 32'(m_owner));
`endif
   endtask

   task automatic drive_data();
      for (int i = 0; i < NR; i++) asi_in_data[i*8 +: 8] = mk(i, drv_seq[i]);
   endtask

   // One clock: drive at posedge+1, check at negedge, advance bench state after posedge.
   task automatic cycle(input logic [NR-1:0] v, input logic r);
      logic [NR-1:0] hs;
      asi_in_valid   = v;
      aso_out0_ready = r;
      drive_data();
      @(negedge clock_clk);
      check_outputs(v, r);
      if (grant_active && !prev_ga) grants.push_back(int'(grant_index));
      prev_ga = grant_active;
      hs = asi_in_valid & asi_in_ready;
      model_step(v, r);
      @(posedge clock_clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) drv_seq[i]++;
   endtask

   task automatic apply_reset();
      reset_reset    = 1'b1;
      asi_in_valid   = '0;
      aso_out0_ready = 1'b1;
      drive_data();
      @(posedge clock_clk);
      #1;
      reset_reset = 1'b0;
      model_reset();
      grants.delete();
   endtask

   initial begin
      int base2;
      for (int i = 0; i < NR; i++) begin
         m_seq[i]   = 0;
         drv_seq[i] = 0;
      end
      model_reset();
      reset_reset    = 1'b1;
      asi_in_valid   = '0;
      aso_out0_ready = 1'b1;
      drive_data();
      #1;
      chk("reset_grant_active", 32'(grant_active), 32'h0);
      chk("reset_grant_index", 32'(grant_index), 32'h0);
      chk("reset_ready", 32'(asi_in_ready), 32'h0);
      chk("reset_valid", 32'(aso_out0_valid), 32'h0);
      chk("reset_data", 32'(aso_out0_data), 32'h0);
      apply_reset();

      // Single requester 1: 0x10..0x17 as two packets with an IDLE gap.
      for (int c = 0; c < 11; c++) cycle(4'b0010, 1'b1);
      chk("single_pkts", 32'(grants.size()), 32'd2);
      chk("single_bytes", 32'(drv_seq[1]), 32'd8);

      // All four valid after reset: strict round robin from requester 0.
      apply_reset();
      for (int c = 0; c < 25; c++) cycle(4'b1111, 1'b1);
      chk("rr_count", 32'(grants.size()), 32'd5);
      if (grants.size() >= 5) begin
         chk("rr_g0", 32'(grants[0]), 32'd0);
         chk("rr_g1", 32'(grants[1]), 32'd1);
         chk("rr_g2", 32'(grants[2]), 32'd2);
         chk("rr_g3", 32'(grants[3]), 32'd3);
         chk("rr_g4", 32'(grants[4]), 32'd0);
      end

      // Backpressure on requester 2 after its 2nd byte.
      grants.delete();
      base2 = drv_seq[2];
      cycle(4'b0100, 1'b1);
      cycle(4'b0100, 1'b1);
      cycle(4'b0100, 1'b1);
      for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b1);
      cycle(4'b0100, 1'b1);
      cycle(4'b0000, 1'b1);
      chk("bp_bytes", 32'(drv_seq[2] - base2), 32'd4);
      chk("bp_done", 32'(grant_active), 32'h0);

      // Reset during requester 1's packet, after its 2nd byte.
      apply_reset();
      for (int c = 0; c < 3; c++) cycle(4'b0010, 1'b1);
      asi_in_valid = 4'b0010;
      drive_data();
      #2;
      reset_reset = 1'b1;
      #1;
      chk("midrst_ready", 32'(asi_in_ready), 32'h0);
      chk("midrst_valid", 32'(aso_out0_valid), 32'h0);
      chk("midrst_ga", 32'(grant_active), 32'h0);
      model_reset();
      grants.delete();
      @(posedge clock_clk);
      #1;
      reset_reset = 1'b0;
      for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1);
      chk("midrst_restart", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF, 32'd0);

      // Requester 0 bubbles mid-packet while requester 3 waits.
      apply_reset();
      for (int c = 0; c < 3; c++) cycle(4'b1001, 1'b1);
      for (int c = 0; c < 5; c++) cycle(4'b1000, 1'b1);
      for (int c = 0; c < 8; c++) cycle(4'b1001, 1'b1);
      chk("bubble_count", 32'(grants.size()), 32'd2);
      if (grants.size() >= 2) begin
         chk("bubble_g0", 32'(grants[0]), 32'd0);
         chk("bubble_g1", 32'(grants[1]), 32'd3);
      end

`ifdef BYTE_STREAM_ARB_CHANNEL_EN
      // Mask skips requesters 1 and 3.
      apply_reset();
      chan_mask = 4'b0101;
      for (int c = 0; c < 20; c++) cycle(4'b1111, 1'b1);
      chk("mask_count", 32'(grants.size()), 32'd4);
      if (grants.size() >= 4) begin
         chk("mask_g0", 32'(grants[0]), 32'd0);
         chk("mask_g1", 32'(grants[1]), 32'd2);
         chk("mask_g2", 32'(grants[2]), 32'd0);
         chk("mask_g3", 32'(grants[3]), 32'd2);
      end
`endif

      // Random valid/ready traffic.
      apply_reset();
      for (int c = 0; c < 400; c++) begin
`ifdef BYTE_STREAM_ARB_CHANNEL_EN
         if (c % 50 == 0) chan_mask = 4'($urandom_range(1, 15));
`endif
         cycle(4'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
